// File: rtl/auth_seq_blk.sv
// Power-authentication gate between uart_rx and the drivetrain enable logic.
// Unlocks on a multi-byte key, with key timeout, wrong-key lockout and debounced rider-off stop.
module auth_seq_blk #(
  parameter int                   KEY_LEN     = 2,
  parameter logic [8*KEY_LEN-1:0] KEY         = {8'h6F, 8'h67},
  parameter logic [7:0]           OFF_CMD     = 8'h73,
  parameter int                   MAX_FAIL    = 3,
  parameter int                   KEY_TO      = 50_000_000,
  parameter int                   OFF_DLY     = 1_000_000,
  parameter int                   LOCK_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       rider_off,
  output logic       clr_rx_rdy,
  output logic       pwr_up,
  output logic       locked,
  output logic       key_err
);

  localparam int IDX_W  = (KEY_LEN > 1)     ? $clog2(KEY_LEN)      : 1;
  localparam int FAIL_W = (MAX_FAIL > 0)    ? $clog2(MAX_FAIL + 1) : 1;
  localparam int KT_W   = (KEY_TO > 1)      ? $clog2(KEY_TO)       : 1;
  localparam int OT_W   = (OFF_DLY > 1)     ? $clog2(OFF_DLY)      : 1;
  localparam int LT_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES)  : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(KEY_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_SAT  = {FAIL_W{1'b1}};
  localparam logic [KT_W-1:0]   KEY_LAST  = KT_W'(KEY_TO - 1);
  localparam logic [OT_W-1:0]   OFF_LAST  = OT_W'(OFF_DLY - 1);
  localparam logic [LT_W-1:0]   LOCK_LAST = LT_W'(LOCK_CYCLES - 1);
  localparam logic [7:0]        KEY_FIRST = KEY[7:0];

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_KEYIN = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [FAIL_W-1:0] fail_cnt, fail_nxt;
  logic [KT_W-1:0]   key_tmr, key_tmr_nxt;
  logic [OT_W-1:0]   off_tmr, off_tmr_nxt;
  logic [LT_W-1:0]   lock_tmr, lock_tmr_nxt;
  logic [7:0]        exp_byte;

  assign exp_byte   = 8'(KEY >> {idx, 3'b000});
  assign clr_rx_rdy = rx_rdy;
  assign pwr_up     = (state == S_RUN) || (state == S_STOP);
  assign locked     = (state == S_LOCK);

  // Timers default to zero so that any state change, including re-entry, starts them cleared.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    fail_nxt     = fail_cnt;
    key_tmr_nxt  = '0;
    off_tmr_nxt  = '0;
    lock_tmr_nxt = '0;
    key_err      = 1'b0;
    case (state)
      S_OFF: begin
        idx_nxt = '0;
        if (rx_rdy && (rx_data == KEY_FIRST)) begin
          if (KEY_LEN == 1) begin
            state_nxt = S_RUN;
            fail_nxt  = '0;
          end else begin
            state_nxt = S_KEYIN;
            idx_nxt   = IDX_W'(1);
          end
        end
      end
      S_KEYIN: begin
        if (rx_rdy) begin
          if (rx_data == exp_byte) begin
            if (idx == IDX_LAST) begin
              state_nxt = S_RUN;
              fail_nxt  = '0;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            key_err  = 1'b1;
            fail_nxt = (fail_cnt == FAIL_SAT) ? fail_cnt : fail_cnt + 1'b1;
            idx_nxt  = '0;
            if ((MAX_FAIL != 0) && (fail_nxt == FAIL_LIM)) begin
              state_nxt = S_LOCK;
            end else begin
              state_nxt = S_OFF;
            end
          end
        end else if (key_tmr == KEY_LAST) begin
          state_nxt = S_OFF;
          idx_nxt   = '0;
        end else begin
          key_tmr_nxt = key_tmr + 1'b1;
        end
      end
      S_RUN: begin
        if (rx_rdy && (rx_data == OFF_CMD)) begin
          state_nxt = rider_off ? S_OFF : S_STOP;
        end
      end
      S_STOP: begin
        // A resume byte takes priority over the rider-off debounce expiring.
        if (rx_rdy && (rx_data == KEY_FIRST)) begin
          state_nxt = S_RUN;
        end else if (rider_off) begin
          if (off_tmr == OFF_LAST) begin
            state_nxt = S_OFF;
          end else begin
            off_tmr_nxt = off_tmr + 1'b1;
          end
        end
      end
      S_LOCK: begin
        if (lock_tmr == LOCK_LAST) begin
          state_nxt = S_OFF;
          fail_nxt  = '0;
        end else begin
          lock_tmr_nxt = lock_tmr + 1'b1;
        end
      end
      default: begin
        state_nxt = S_OFF;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OFF;
      idx      <= '0;
      fail_cnt <= '0;
      key_tmr  <= '0;
      off_tmr  <= '0;
      lock_tmr <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      fail_cnt <= fail_nxt;
      key_tmr  <= key_tmr_nxt;
      off_tmr  <= off_tmr_nxt;
      lock_tmr <= lock_tmr_nxt;
    end
  end

endmodule

// File: tb/tb_auth_seq_blk.sv
// Directed self-checking bench for auth_seq_blk with short timer overrides.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_auth_seq_blk;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rider_off;
  logic       clr_rx_rdy;
  logic       pwr_up;
  logic       locked;
  logic       key_err;

  int checks = 0;
  int errors = 0;
  logic c_clr, c_err;

  auth_seq_blk #(
    .KEY_TO(100),
    .OFF_DLY(8),
    .LOCK_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .rider_off(rider_off),
    .clr_rx_rdy(clr_rx_rdy),
    .pwr_up(pwr_up),
    .locked(locked),
    .key_err(key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called on a falling edge; presents one byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] b, output logic clr_o, output logic err_o);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    clr_o = clr_rx_rdy;
    err_o = key_err;
    @(negedge clk);
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rider_off = 1'b0;
    idle(2);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwr_up: got %b want 0", pwr_up); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    checks++; if (key_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_err: got %b want 0", key_err); end
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr: got %b want 0", clr_rx_rdy); end
    rst = 1'b0;
  endtask

  task automatic test_unlock();
    send_byte(8'h41, c_clr, c_err);
    checks++; if (c_err !== 1'b0) begin errors++; $display("[TB] FAIL off_ignore_err: got %b want 0", c_err); end
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL off_ignore_pwr: got %b want 0", pwr_up); end
    send_byte(8'h67, c_clr, c_err);
    checks++; if (c_clr !== 1'b1) begin errors++; $display("[TB] FAIL unlock_clr_hi: got %b want 1", c_clr); end
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL unlock_partial_pwr: got %b want 0", pwr_up); end
    #1;
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("[TB] FAIL unlock_clr_lo: got %b want 0", clr_rx_rdy); end
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (c_err !== 1'b0) begin errors++; $display("[TB] FAIL unlock_key_err: got %b want 0", c_err); end
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL unlock_pwr: got %b want 1", pwr_up); end
  endtask

  task automatic test_stop_debounce();
    rider_off = 1'b0;
    send_byte(8'h73, c_clr, c_err);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL stop_enter_pwr: got %b want 1", pwr_up); end
    rider_off = 1'b1;
    idle(7);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL stop_7cyc_pwr: got %b want 1", pwr_up); end
    rider_off = 1'b0;
    idle(1);
    rider_off = 1'b1;
    idle(7);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL stop_restart_pwr: got %b want 1", pwr_up); end
    idle(1);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL stop_expire_pwr: got %b want 0", pwr_up); end
    rider_off = 1'b0;
  endtask

  task automatic test_resume_race();
    send_byte(8'h67, c_clr, c_err);
    send_byte(8'h6F, c_clr, c_err);
    send_byte(8'h73, c_clr, c_err);
    rider_off = 1'b1;
    idle(7);
    send_byte(8'h67, c_clr, c_err);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL resume_race_pwr: got %b want 1", pwr_up); end
    idle(10);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL run_rider_off_pwr: got %b want 1", pwr_up); end
    send_byte(8'h73, c_clr, c_err);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL stop_cmd_rider_off: got %b want 0", pwr_up); end
    rider_off = 1'b0;
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h67, c_clr, c_err);
      send_byte(8'h41, c_clr, c_err);
      checks++; if (c_err !== 1'b1) begin errors++; $display("[TB] FAIL lock_key_err_%0d: got %b want 1", i, c_err); end
      checks++; if (locked !== (i == 2)) begin errors++; $display("[TB] FAIL lock_state_%0d: got %b want %b", i, locked, (i == 2)); end
    end
    send_byte(8'h67, c_clr, c_err);
    checks++; if (c_err !== 1'b0) begin errors++; $display("[TB] FAIL lock_ignore_err: got %b want 0", c_err); end
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL lock_ignore_pwr: got %b want 0", pwr_up); end
    idle(61);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_hold_63: got %b want 1", locked); end
    idle(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_release: got %b want 0", locked); end
    send_byte(8'h67, c_clr, c_err);
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL unlock_after_lock: got %b want 1", pwr_up); end
    rider_off = 1'b1;
    send_byte(8'h73, c_clr, c_err);
    rider_off = 1'b0;
    send_byte(8'h67, c_clr, c_err);
    send_byte(8'h41, c_clr, c_err);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL fail_cnt_cleared: locked got %b want 0", locked); end
  endtask

  task automatic test_key_timeout();
    send_byte(8'h67, c_clr, c_err);
    idle(99);
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL timeout_race_pwr: got %b want 1", pwr_up); end
    rider_off = 1'b1;
    send_byte(8'h73, c_clr, c_err);
    rider_off = 1'b0;
    send_byte(8'h67, c_clr, c_err);
    idle(100);
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (c_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_key_err: got %b want 0", c_err); end
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pwr: got %b want 0", pwr_up); end
  endtask

  task automatic test_reset_midkey();
    send_byte(8'h67, c_clr, c_err);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL midkey_rst_pwr: got %b want 0", pwr_up); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midkey_rst_locked: got %b want 0", locked); end
    send_byte(8'h6F, c_clr, c_err);
    checks++; if (c_err !== 1'b0) begin errors++; $display("[TB] FAIL midkey_rst_err: got %b want 0", c_err); end
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL midkey_rst_unlock: got %b want 0", pwr_up); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_stop_debounce();
    test_resume_race();
    test_lockout();
    test_key_timeout();
    test_reset_midkey();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
